// File: rtl/clip_pkg.sv
// Shared types and helpers for the clip/requantise pipeline.
//   round_mode_e : rounding selector carried with each input beat
//   clip_max/min : signed saturation bounds for a given output width
//   popcount     : number of set bits, used by the saturation counter
package clip_pkg;

   typedef enum logic {
      RND_TRUNC   = 1'b0,
      RND_HALF_UP = 1'b1
   } round_mode_e;

   function automatic longint clip_max(input int bw);
      return (longint'(1) <<< (bw - 1)) - 1;
   endfunction

   function automatic longint clip_min(input int bw);
      return -(longint'(1) <<< (bw - 1));
   endfunction

   function automatic int popcount(input logic [63:0] v);
      int n = 0;
      for (int i = 0; i < 64; i++) n += int'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/clip_requant_pipe_if.sv
// Valid/ready stream bundle for clip_requant_pipe.
//   master : producer of input beats / consumer of output beats (testbench, upstream)
//   slave  : the requantiser itself
// Signals: in_valid/in_ready/in_data/in_shift/in_round (input side),
//          out_valid/out_ready/out_data/out_sat (output side).
interface clip_requant_pipe_if #(
   parameter int CHANNELS  = 4,
   parameter int INPUT_BW  = 32,
   parameter int TARGET_BW = 8,
   parameter int SHIFT_BW  = $clog2(INPUT_BW)
) ();
   logic                          in_valid;
   logic                          in_ready;
   logic [CHANNELS*INPUT_BW-1:0]  in_data;
   logic [SHIFT_BW-1:0]           in_shift;
   logic                          in_round;
   logic                          out_valid;
   logic                          out_ready;
   logic [CHANNELS*TARGET_BW-1:0] out_data;
   logic [CHANNELS-1:0]           out_sat;

   modport master (
      output in_valid, in_data, in_shift, in_round, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  in_valid, in_data, in_shift, in_round, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/clip_lane.sv
// One requantiser lane: stage 1 rounds and arithmetic-shifts right, stage 2
// saturates to TARGET_BW. No handshake logic; the enables come from the top.
// Ports: clk, rst_n, s1_adv/s2_adv (stage load enables), lane_in (signed),
//        shift_in, round_in, lane_out (signed, clipped), sat_out (clipped flag).
module clip_lane
   import clip_pkg::*;
#(
   parameter int INPUT_BW  = 32,
   parameter int TARGET_BW = 8,
   parameter int SHIFT_BW  = $clog2(INPUT_BW)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s1_adv,
   input  logic                        s2_adv,
   input  logic signed [INPUT_BW-1:0]  lane_in,
   input  logic [SHIFT_BW-1:0]         shift_in,
   input  logic                        round_in,
   output logic signed [TARGET_BW-1:0] lane_out,
   output logic                        sat_out
);
   // One guard bit so that adding the rounding constant to +max cannot wrap.
   localparam int EXT_BW = INPUT_BW + 1;
   localparam logic signed [EXT_BW-1:0] MAX_V = EXT_BW'(clip_max(TARGET_BW));
   localparam logic signed [EXT_BW-1:0] MIN_V = EXT_BW'(clip_min(TARGET_BW));

   logic [SHIFT_BW:0]          sh_wide;
   logic [SHIFT_BW-1:0]        sh;
   round_mode_e                mode;
   logic signed [EXT_BW-1:0]   ext;
   logic signed [EXT_BW-1:0]   rnd_add;
   logic signed [EXT_BW-1:0]   shifted;
   logic signed [EXT_BW-1:0]   s1_q;
   logic signed [TARGET_BW-1:0] clip_nxt;
   logic                       sat_nxt;

   assign sh_wide = {1'b0, shift_in};
   assign sh      = (sh_wide > (SHIFT_BW+1)'(INPUT_BW - 1)) ? SHIFT_BW'(INPUT_BW - 1) : shift_in;
   assign mode    = round_mode_e'(round_in);
   assign ext     = {lane_in[INPUT_BW-1], lane_in};
   assign rnd_add = (mode == RND_HALF_UP && sh != '0) ? (EXT_BW'(1) << (sh - SHIFT_BW'(1))) : '0;
   assign shifted = (ext + rnd_add) >>> sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      s1_q <= '0;
      else if (s1_adv) s1_q <= shifted;
   end

   always_comb begin
      clip_nxt = s1_q[TARGET_BW-1:0];
      sat_nxt  = 1'b0;
      if (s1_q > MAX_V) begin
         clip_nxt = MAX_V[TARGET_BW-1:0];
         sat_nxt  = 1'b1;
      end else if (s1_q < MIN_V) begin
         clip_nxt = MIN_V[TARGET_BW-1:0];
         sat_nxt  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_out <= '0;
         sat_out  <= 1'b0;
      end else if (s2_adv) begin
         lane_out <= clip_nxt;
         sat_out  <= sat_nxt;
      end
   end
endmodule

// File: rtl/clip_requant_pipe.sv
// Multi-lane pipelined requantiser: per-lane round/shift then saturate, two
// register stages, valid/ready flow control with no skid buffer (in_ready is
// combinational from out_ready), and a saturating count of clipped lane results.
// Optional feature macro: CLIP_SAT_CNT_EN. When undefined sat_cnt reads 0,
// sat_clr is ignored and no counter flops exist; out_sat is always present.
// Ports: clk, rst_n (async active-low), bus (clip_requant_pipe_if.slave),
//        sat_clr (sync clear of sat_cnt), sat_cnt (saturation event count).
module clip_requant_pipe
   import clip_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int INPUT_BW  = 32,
   parameter int TARGET_BW = 8,
   parameter int SHIFT_BW  = $clog2(INPUT_BW),
   parameter int CNT_BW    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   clip_requant_pipe_if.slave bus,
   input  logic              sat_clr,
   output logic [CNT_BW-1:0] sat_cnt
);
   logic s1_valid, s2_valid;
   logic s1_adv, s2_adv;
   logic out_xfer;
   logic [CHANNELS*TARGET_BW-1:0] out_data_w;
   logic [CHANNELS-1:0]           out_sat_w;

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv;
   assign bus.out_valid = s2_valid;
   assign bus.out_data = out_data_w;
   assign bus.out_sat  = out_sat_w;
   assign out_xfer     = s2_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= bus.in_valid;
         if (s2_adv) s2_valid <= s1_valid;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      clip_lane #(
         .INPUT_BW  (INPUT_BW),
         .TARGET_BW (TARGET_BW),
         .SHIFT_BW  (SHIFT_BW)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .s1_adv   (s1_adv),
         .s2_adv   (s2_adv),
         .lane_in  (bus.in_data[g*INPUT_BW +: INPUT_BW]),
         .shift_in (bus.in_shift),
         .round_in (bus.in_round),
         .lane_out (out_data_w[g*TARGET_BW +: TARGET_BW]),
         .sat_out  (out_sat_w[g])
      );
   end

`ifdef CLIP_SAT_CNT_EN
   // One extra bit catches the carry so the count pins at all-ones.
   logic [CNT_BW:0] cnt_sum;
   assign cnt_sum = {1'b0, sat_cnt} + (CNT_BW+1)'(popcount(64'(out_sat_w)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        sat_cnt <= '0;
      else if (sat_clr)  sat_cnt <= '0;
      else if (out_xfer) sat_cnt <= cnt_sum[CNT_BW] ? '1 : cnt_sum[CNT_BW-1:0];
   end
`else
   logic unused_cnt_inputs;
   assign unused_cnt_inputs = sat_clr ^ out_xfer;
   assign sat_cnt = '0;
`endif
endmodule

// File: doc/clip_requant_pipe.md
Name: clip_requant_pipe

Overview:
- Multi-channel, pipelined requantiser. Each lane does a runtime arithmetic right shift with optional round-half-up, then saturates to TARGET_BW.
- Sits between the adder-tree accumulator outputs and the next layer's narrow operand buffers.
- Replaces the single-lane combinational clip. Adds the shift/round stage, valid/ready flow control, per-lane saturation flags and a saturation-event counter.

Parameters:
CHANNELS, 4, number of parallel lanes
INPUT_BW, 32, signed input width per lane
TARGET_BW, 8, signed output width per lane (2 <= TARGET_BW < INPUT_BW)
SHIFT_BW, $clog2(INPUT_BW), width of shift amount
CNT_BW, 16, saturation counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input beat
in_data  in  CHANNELS*INPUT_BW  packed signed lanes, lane 0 in LSBs
in_shift  in  SHIFT_BW  right-shift amount, sampled with the beat
in_round  in  1  1 = round-half-up, 0 = truncate (floor)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
out_data  out  CHANNELS*TARGET_BW  packed signed clipped lanes
out_sat  out  CHANNELS  per-lane flag: value was clipped this beat
sat_clr  in  1  synchronous clear of sat_cnt
sat_cnt  out  CNT_BW  number of saturated lane-results delivered

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sat=0, sat_cnt=0. in_ready=1 once reset is released.
- Reset mid-stream drops all in-flight beats. No output is produced for them.
- Two register stages. Latency is exactly 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 beat/cycle.
- Flow control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no skid buffer)
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - out_data and out_sat hold stable while out_valid && !out_ready. Beat order is preserved.
- Stage 1, per lane:
  - Effective shift sh = min(in_shift, INPUT_BW-1).
  - Extend to INPUT_BW+1 bits.
  - If in_round && sh>0, add 2^(sh-1).
  - Arithmetic-shift right by sh. Register the INPUT_BW+1-bit result.
  - The extra bit guarantees no overflow when rounding near +max.
- Stage 2, per lane:
  - MAX = 2^(TARGET_BW-1)-1, MIN = -2^(TARGET_BW-1).
  - v > MAX gives MAX with sat=1. v < MIN gives MIN with sat=1. Otherwise v[TARGET_BW-1:0] with sat=0.
  - Comparisons are signed at full width.
- sat_cnt:
  - On each output transfer, add popcount(out_sat) and saturate at all-ones (no wrap).
  - sat_clr=1 forces 0 next cycle and has priority over a same-cycle increment.
- Bubbles (in_valid=0) propagate as s*_valid=0. Invalid stage contents are don't-care but must not update sat_cnt.

Optional Feature:
Macro: CLIP_SAT_CNT_EN.
- Defined: sat_cnt logic as above.
- Undefined:
  - sat_cnt is tied to 0 and sat_clr is ignored.
  - No counter flops are synthesised.
  - out_sat remains present and functional.

Decomposition:
- Package clip_pkg holds:
  - typedef round_mode_e {RND_TRUNC=0, RND_HALF_UP=1}
  - function clip_max(bw) / clip_min(bw) returning the saturation bounds
  - function popcount used by the counter
- Sub-module clip_lane: one lane's stage-1 round/shift and stage-2 saturate datapath.
  - Takes enable inputs s1_adv/s2_adv and has no handshake logic.
  - Instantiated CHANNELS times by generate.
- Top-level owns the valid pipeline, handshake and counter.

Test Plan (INPUT_BW=32, TARGET_BW=8, CHANNELS=4, CLIP_SAT_CNT_EN defined):
- shift=0, trunc, lanes {127,128,-128,-129}, out_ready=1 -> 2 cycles later out_data {127,127,-128,-128}, out_sat=4'b1010, sat_cnt=2.
- shift=4, lanes {24,-24,24,-24}, lanes 0-1 round=1, lanes 2-3 sent as a second beat with round=0 -> beat1 {2,-1}, beat2 {1,-2}, out_sat=0.
- shift=1, round=1, lane 0x7FFFFFFF -> intermediate 2^30 with no overflow; output 127, sat=1. Lane 0x80000000 -> -128, sat=1.
- Stream of 6 beats with out_ready low for cycles 3-6:
  - in_ready falls once both stages are full.
  - No beat is lost or duplicated; order is preserved.
  - out_data is stable while stalled.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0 and sat_cnt=0 immediately (async). After release, the next beat emerges with 2-cycle latency.
- Force sat_cnt near max with repeated 4-lane saturating beats -> sticks at 16'hFFFF. sat_clr together with a saturating beat -> 0.
